// File: rtl/dmb_cal_pkg.sv
// dmb_cal_pkg: shared types and constants for the calibration trigger scheduler.
// Holds the scheduler state enum, sequence source codes, sequence timing lengths,
// the LFSR seed and small decode helpers.
package dmb_cal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } cal_state_t;

  typedef enum logic [1:0] {
    SRC_PULSE  = 2'd0,
    SRC_INJECT = 2'd1,
    SRC_PED    = 2'd2
  } cal_src_t;

  localparam int          HOLDOFF_LEN = 16;
  localparam int          ACTIVE_LEN  = 32;
  localparam int          BURST_LEN   = 32;
  localparam logic [22:0] LFSR_SEED   = 23'h1;

  // SRC_SEL codes 2 and 3 both mean pedestal
  function automatic cal_src_t src_decode(input logic [1:0] sel);
    cal_src_t s;
    case (sel)
      2'd0:    s = SRC_PULSE;
      2'd1:    s = SRC_INJECT;
      default: s = SRC_PED;
    endcase
    return s;
  endfunction

  // Jitter width code to mask applied to the random word
  function automatic logic [11:0] jitter_mask(input logic [1:0] code);
    logic [11:0] m;
    case (code)
      2'd0:    m = 12'h000;
      2'd1:    m = 12'h00F;
      2'd2:    m = 12'h0FF;
      default: m = 12'hFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cal_lfsr.sv
// cal_lfsr: 23-bit maximal-length Fibonacci LFSR (x^23 + x^18 + 1) used to
// jitter the periodic trigger interval. Only the low 12 bits are needed.
module cal_lfsr
  import dmb_cal_pkg::*;
(
  input  logic        CLKCMS,
  input  logic        RST_N,
  output logic [11:0] rnd
);

  logic [22:0] lfsr_reg;

  // Free-running shift register; seed must be nonzero or it locks up
  always_ff @(posedge CLKCMS or negedge RST_N) begin
    if (!RST_N) lfsr_reg <= LFSR_SEED;
    else        lfsr_reg <= {lfsr_reg[21:0], lfsr_reg[22] ^ lfsr_reg[17]};
  end

  assign rnd = lfsr_reg[11:0];

endmodule

// File: rtl/cal_trg_sched.sv
// cal_trg_sched: calibration trigger scheduler. Arbitrates CCB calibration
// requests, JTAG burst and periodic triggers into fixed 48-cycle sequences
// (32 active + 16 holdoff) emitting delayed PULSE/INJECT/LCT_RQST/CAL_GTRG.
// Optional build macro CAL_SCHED_RANDOM_EN adds LFSR jitter to the period.
module cal_trg_sched
  import dmb_cal_pkg::*;
(
  input  logic        CLKCMS,
  input  logic        RST_N,
  input  logic        CCBPLS,
  input  logic        CCBINJ,
  input  logic        CCBPED,
  input  logic        RTRG_TGL,
  input  logic        BURST,
  input  logic        CLR_CNT,
  input  logic [17:0] TRG_RATE,
  input  logic [1:0]  SRC_SEL,
  input  logic [4:0]  INJ_DLY,
  input  logic [4:0]  PLS_DLY,
  input  logic [4:0]  L1A_DLY,
  input  logic [3:0]  LCT_DLY,
  output logic        INJECT,
  output logic        PULSE,
  output logic        LCT_RQST,
  output logic        CAL_GTRG,
  output logic        BUSY,
  output logic        RUN,
  output logic [15:0] TRG_CNT,
  output logic [7:0]  MISS_CNT
);

  localparam logic [4:0] ACTIVE_LAST  = 5'(ACTIVE_LEN - 1);
  localparam logic [4:0] HOLDOFF_LAST = 5'(HOLDOFF_LEN - 1);
  localparam logic [5:0] BURST_LOAD   = 6'(BURST_LEN);

  cal_state_t  state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  cal_src_t    src_reg, src_next;
  logic        pend_valid_reg, pend_valid_next;
  cal_src_t    pend_src_reg, pend_src_next;
  logic [5:0]  burst_cnt_reg, burst_cnt_next;
  logic [16:0] per_cnt_reg;
  logic [16:0] per_target;
  logic        run_reg;
  logic [15:0] trg_cnt_reg;
  logic [7:0]  miss_cnt_reg;
  logic [3:0]  strobe_reg, strobe_next;
  logic        busy_reg;

  logic        ccb_any, can_accept, per_run, per_fire;
  logic        accept, take_pend, take_burst, take_per;
  cal_src_t    ccb_src, sel_src;

  assign ccb_any = CCBPLS | CCBINJ | CCBPED;
  assign sel_src = src_decode(SRC_SEL);
  // The last holdoff cycle hands over straight to a new sequence so that
  // back-to-back sequences start exactly 48 cycles apart.
  assign can_accept = (state_reg == ST_IDLE) ||
                      ((state_reg == ST_HOLDOFF) && (cnt_reg == HOLDOFF_LAST));

  // Highest-priority CCB bit wins; the others in the same cycle are dropped
  always_comb begin
    ccb_src = SRC_PED;
    if (CCBPLS)      ccb_src = SRC_PULSE;
    else if (CCBINJ) ccb_src = SRC_INJECT;
  end

  // Period counter target, optionally stretched by random jitter
  assign per_run = run_reg && (TRG_RATE[15:0] != 16'd0);
`ifdef CAL_SCHED_RANDOM_EN
  logic [11:0] rnd;
  logic [11:0] jit_reg;

  cal_lfsr u_lfsr (
    .CLKCMS (CLKCMS),
    .RST_N  (RST_N),
    .rnd    (rnd)
  );

  // New jitter sample on every reload and while idle, used for the next period
  always_ff @(posedge CLKCMS or negedge RST_N) begin
    if (!RST_N)                  jit_reg <= 12'd0;
    else if (!per_run || per_fire) jit_reg <= rnd & jitter_mask(TRG_RATE[17:16]);
  end

  assign per_target = {1'b0, TRG_RATE[15:0]} + {5'd0, jit_reg};
`else
  logic unused_rate_hi;
  assign unused_rate_hi = ^TRG_RATE[17:16];
  assign per_target     = {1'b0, TRG_RATE[15:0]};
`endif
  assign per_fire = per_run && (per_cnt_reg >= (per_target - 17'd1));

  // Arbitration and FSM next-state
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    src_next   = src_reg;
    accept     = 1'b0;
    take_pend  = 1'b0;
    take_burst = 1'b0;
    take_per   = 1'b0;
    if (can_accept) begin
      if (pend_valid_reg) begin
        accept    = 1'b1;
        take_pend = 1'b1;
        src_next  = pend_src_reg;
      end else if (ccb_any) begin
        accept   = 1'b1;
        src_next = ccb_src;
      end else if (burst_cnt_reg != 6'd0) begin
        accept     = 1'b1;
        take_burst = 1'b1;
        src_next   = sel_src;
      end else if (per_fire) begin
        accept   = 1'b1;
        take_per = 1'b1;
        src_next = sel_src;
      end
    end
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_ACTIVE;
          cnt_next   = 5'd0;
        end
      end
      ST_ACTIVE: begin
        if (cnt_reg == ACTIVE_LAST) begin
          state_next = ST_HOLDOFF;
          cnt_next   = 5'd0;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_reg == HOLDOFF_LAST) begin
          state_next = accept ? ST_ACTIVE : ST_IDLE;
          cnt_next   = 5'd0;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 5'd0;
      end
    endcase
  end

  // Pending slot and burst counter next values
  always_comb begin
    pend_valid_next = pend_valid_reg;
    pend_src_next   = pend_src_reg;
    burst_cnt_next  = burst_cnt_reg;
    if (take_pend) begin
      pend_valid_next = 1'b0;
    end else if (ccb_any && !pend_valid_reg && !can_accept) begin
      pend_valid_next = 1'b1;
      pend_src_next   = ccb_src;
    end
    if (take_burst)                          burst_cnt_next = burst_cnt_reg - 6'd1;
    else if (BURST && burst_cnt_reg == 6'd0) burst_cnt_next = BURST_LOAD;
  end

  // Strobe decode: each output fires when the sequence counter equals its delay
  logic [4:0] dly [4];
  logic [3:0] kind_ok;
  assign dly[0]  = INJ_DLY;
  assign dly[1]  = PLS_DLY;
  assign dly[2]  = {1'b0, LCT_DLY};
  assign dly[3]  = L1A_DLY;
  assign kind_ok = {1'b1, 1'b1, src_reg == SRC_PULSE, src_reg == SRC_INJECT};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_strobe
      assign strobe_next[gi] = (state_reg == ST_ACTIVE) && kind_ok[gi] && (cnt_reg == dly[gi]);
    end
  endgenerate

  // FSM state register
  always_ff @(posedge CLKCMS or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 5'd0;
      src_reg   <= SRC_PED;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      src_reg   <= src_next;
    end
  end

  // Request bookkeeping: pending slot, burst count, run flag, period counter
  always_ff @(posedge CLKCMS or negedge RST_N) begin
    if (!RST_N) begin
      pend_valid_reg <= 1'b0;
      pend_src_reg   <= SRC_PED;
      burst_cnt_reg  <= 6'd0;
      run_reg        <= 1'b0;
      per_cnt_reg    <= 17'd0;
    end else begin
      pend_valid_reg <= pend_valid_next;
      pend_src_reg   <= pend_src_next;
      burst_cnt_reg  <= burst_cnt_next;
      if (RTRG_TGL) run_reg <= !run_reg;
      if (!per_run || per_fire) per_cnt_reg <= 17'd0;
      else                      per_cnt_reg <= per_cnt_reg + 17'd1;
    end
  end

  // Trigger and miss counters; clear takes precedence over counting
  always_ff @(posedge CLKCMS or negedge RST_N) begin
    if (!RST_N) begin
      trg_cnt_reg  <= 16'd0;
      miss_cnt_reg <= 8'd0;
    end else if (CLR_CNT) begin
      trg_cnt_reg  <= 16'd0;
      miss_cnt_reg <= 8'd0;
    end else begin
      if (accept) trg_cnt_reg <= trg_cnt_reg + 16'd1;
      if (per_fire && !take_per && miss_cnt_reg != 8'hFF)
        miss_cnt_reg <= miss_cnt_reg + 8'd1;
    end
  end

  // Registered strobes and busy flag
  always_ff @(posedge CLKCMS or negedge RST_N) begin
    if (!RST_N) begin
      strobe_reg <= 4'd0;
      busy_reg   <= 1'b0;
    end else begin
      strobe_reg <= strobe_next;
      busy_reg   <= (state_next != ST_IDLE) | pend_valid_next | (burst_cnt_next != 6'd0);
    end
  end

  assign INJECT   = strobe_reg[0];
  assign PULSE    = strobe_reg[1];
  assign LCT_RQST = strobe_reg[2];
  assign CAL_GTRG = strobe_reg[3];
  assign BUSY     = busy_reg;
  assign RUN      = run_reg;
  assign TRG_CNT  = trg_cnt_reg;
  assign MISS_CNT = miss_cnt_reg;

endmodule

// File: tb/tb_cal_trg_sched.sv
// tb_cal_trg_sched: scoreboard bench for cal_trg_sched (default build).
// A timeline model predicts, per clock edge, the expected strobes and status;
// a monitor on the falling edge pops and compares.
`timescale 1ns/1ps
module tb_cal_trg_sched;

  logic        CLKCMS = 1'b0;
  logic        RST_N  = 1'b0;
  logic        CCBPLS = 1'b0, CCBINJ = 1'b0, CCBPED = 1'b0;
  logic        RTRG_TGL = 1'b0, BURST = 1'b0, CLR_CNT = 1'b0;
  logic [17:0] TRG_RATE = 18'd0;
  logic [1:0]  SRC_SEL = 2'd0;
  logic [4:0]  INJ_DLY = 5'd0, PLS_DLY = 5'd0, L1A_DLY = 5'd0;
  logic [3:0]  LCT_DLY = 4'd0;
  logic        INJECT, PULSE, LCT_RQST, CAL_GTRG, BUSY, RUN;
  logic [15:0] TRG_CNT;
  logic [7:0]  MISS_CNT;

  cal_trg_sched dut (
    .CLKCMS(CLKCMS), .RST_N(RST_N),
    .CCBPLS(CCBPLS), .CCBINJ(CCBINJ), .CCBPED(CCBPED),
    .RTRG_TGL(RTRG_TGL), .BURST(BURST), .CLR_CNT(CLR_CNT),
    .TRG_RATE(TRG_RATE), .SRC_SEL(SRC_SEL),
    .INJ_DLY(INJ_DLY), .PLS_DLY(PLS_DLY), .L1A_DLY(L1A_DLY), .LCT_DLY(LCT_DLY),
    .INJECT(INJECT), .PULSE(PULSE), .LCT_RQST(LCT_RQST), .CAL_GTRG(CAL_GTRG),
    .BUSY(BUSY), .RUN(RUN), .TRG_CNT(TRG_CNT), .MISS_CNT(MISS_CNT)
  );

  always #12.5 CLKCMS = ~CLKCMS;

  typedef struct packed {
    logic [3:0]  stb;   // {CAL_GTRG, LCT_RQST, PULSE, INJECT}
    logic        busy;
    logic        run;
    logic [15:0] trg;
    logic [7:0]  miss;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: a sequence is an accept time plus a type
  longint edge_no = 0;
  bit     m_have  = 0;
  longint m_acc   = 0;
  int     m_type  = 0;     // 0 pulse, 1 inject, 2 pedestal
  bit     m_pend  = 0;
  int     m_pend_t = 0;
  int     m_burst = 0;
  bit     m_run   = 0;
  longint m_t0    = 0;
  int     m_trg   = 0;
  int     m_miss  = 0;

  always @(posedge CLKCMS) begin : model
    exp_t   x;
    longint el;
    bit     idle, fire, ccb, acc, per_taken;
    int     ccbt, selt, t, rate, burst_before;
    edge_no++;
    x = '0;
    if (!RST_N) begin
      m_have = 0; m_pend = 0; m_burst = 0; m_run = 0; m_trg = 0; m_miss = 0;
    end else begin
      // strobes of the sequence already running
      if (m_have) begin
        el = edge_no - 1 - m_acc;
        if (el >= 0 && el < 32) begin
          x.stb[0] = (m_type == 1) && (el == longint'(INJ_DLY));
          x.stb[1] = (m_type == 0) && (el == longint'(PLS_DLY));
          x.stb[2] = (el == longint'(LCT_DLY));
          x.stb[3] = (el == longint'(L1A_DLY));
        end
      end
      idle = !m_have || (edge_no >= m_acc + 48);
      rate = int'(TRG_RATE[15:0]);
      fire = m_run && (rate != 0) && (((edge_no - m_t0) % rate) == 0);
      ccb  = CCBPLS | CCBINJ | CCBPED;
      ccbt = CCBPLS ? 0 : (CCBINJ ? 1 : 2);
      selt = (SRC_SEL == 2'd0) ? 0 : ((SRC_SEL == 2'd1) ? 1 : 2);
      acc = 0; per_taken = 0; t = 0;
      burst_before = m_burst;
      if (idle) begin
        if (m_pend)             begin acc = 1; t = m_pend_t; m_pend = 0; end
        else if (ccb)           begin acc = 1; t = ccbt; end
        else if (m_burst > 0)   begin acc = 1; t = selt; m_burst--; end
        else if (fire)          begin acc = 1; t = selt; per_taken = 1; end
      end else if (ccb && !m_pend) begin
        m_pend = 1; m_pend_t = ccbt;
      end
      if (BURST && burst_before == 0) m_burst = 32;
      if (CLR_CNT) begin
        m_trg = 0; m_miss = 0;
      end else begin
        if (acc) m_trg = (m_trg + 1) & 16'hFFFF;
        if (fire && !per_taken && m_miss < 255) m_miss++;
      end
      if (RTRG_TGL) begin
        m_run = !m_run;
        if (m_run) m_t0 = edge_no;
      end
      if (acc) begin m_have = 1; m_acc = edge_no; m_type = t; end
      x.busy = (m_have && (edge_no - m_acc) <= 47) || m_pend || (m_burst != 0);
      x.run  = m_run;
      x.trg  = 16'(m_trg);
      x.miss = 8'(m_miss);
    end
    exp_q.push_back(x);
  end

  // Monitor: one expectation per clock, compared mid-cycle
  always @(negedge CLKCMS) begin : monitor
    exp_t x;
    logic [3:0] got_stb;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL queue_empty at edge %0d", edge_no);
    end else begin
      x = exp_q.pop_front();
      if (!RST_N) x = '0;
      got_stb = {CAL_GTRG, LCT_RQST, PULSE, INJECT};
      n_checks++;
      if (got_stb !== x.stb) begin
        n_fail++;
        $display("FAIL strobes edge %0d: got %b required %b", edge_no, got_stb, x.stb);
      end
      n_checks++;
      if ({BUSY, RUN, TRG_CNT, MISS_CNT} !== {x.busy, x.run, x.trg, x.miss}) begin
        n_fail++;
        $display("FAIL status edge %0d: got busy=%b run=%b trg=%0d miss=%0d required busy=%b run=%b trg=%0d miss=%0d",
                 edge_no, BUSY, RUN, TRG_CNT, MISS_CNT, x.busy, x.run, x.trg, x.miss);
      end
    end
  end

  localparam logic [5:0] P_PLS = 6'b100000, P_INJ = 6'b010000, P_PED = 6'b001000;
  localparam logic [5:0] P_TGL = 6'b000100, P_BST = 6'b000010, P_CLR = 6'b000001;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLKCMS);
    #2;
  endtask

  task automatic cyc(input logic [5:0] s);
    {CCBPLS, CCBINJ, CCBPED, RTRG_TGL, BURST, CLR_CNT} = s;
    wait_cyc(1);
    {CCBPLS, CCBINJ, CCBPED, RTRG_TGL, BURST, CLR_CNT} = 6'd0;
  endtask

  initial begin
    logic [5:0] s;
    wait_cyc(3);
    RST_N = 1'b1;
    wait_cyc(2);

    // single pulse sequence
    PLS_DLY = 5'd13; LCT_DLY = 4'd8; L1A_DLY = 5'd11; INJ_DLY = 5'd15;
    $display("txn: CCBPLS pls=13 lct=8 l1a=11");
    cyc(P_PLS); wait_cyc(60);
    // inject beats pedestal in the same cycle
    $display("txn: CCBINJ+CCBPED inj=15");
    cyc(P_INJ | P_PED); wait_cyc(60);
    // pedestal during an active sequence goes to the pending slot
    $display("txn: CCBPLS then CCBPED at cycle 10");
    cyc(P_PLS); wait_cyc(9); cyc(P_PED); wait_cyc(100);
    // extreme delays
    PLS_DLY = 5'd31; L1A_DLY = 5'd0; LCT_DLY = 4'd15; INJ_DLY = 5'd31;
    $display("txn: CCBINJ extreme delays");
    cyc(P_INJ); wait_cyc(55);
    // burst of pulse sequences, second BURST ignored
    SRC_SEL = 2'd0; PLS_DLY = 5'd3; L1A_DLY = 5'd7; LCT_DLY = 4'd2;
    $display("txn: BURST src=0");
    cyc(P_BST); wait_cyc(200); cyc(P_BST); wait_cyc(1450);
    // periodic triggers every 20 cycles
    TRG_RATE = 18'h00014; SRC_SEL = 2'd1;
    $display("txn: periodic rate=20");
    cyc(P_TGL); wait_cyc(150); cyc(P_CLR); wait_cyc(150); cyc(P_TGL); wait_cyc(60);
    // miss counter saturation: fast periodic against a burst
    TRG_RATE = 18'h00003; SRC_SEL = 2'd2;
    $display("txn: periodic rate=3 with burst");
    cyc(P_TGL); cyc(P_BST); wait_cyc(1600); cyc(P_PLS | P_CLR); wait_cyc(40);
    cyc(P_TGL); wait_cyc(60);
    // reset in the middle of a sequence
    INJ_DLY = 5'd10; LCT_DLY = 4'd9; L1A_DLY = 5'd12;
    $display("txn: CCBINJ then reset at cycle 5");
    cyc(P_INJ); wait_cyc(4);
    RST_N = 1'b0; wait_cyc(3); RST_N = 1'b1; wait_cyc(40);

    // randomized traffic
    TRG_RATE = 18'd0;
    for (int i = 0; i < 3000; i++) begin
      s = 6'd0;
      s[5] = ($urandom_range(0, 99) < 3);
      s[4] = ($urandom_range(0, 99) < 3);
      s[3] = ($urandom_range(0, 99) < 3);
      s[2] = ($urandom_range(0, 99) < 1);
      s[1] = ($urandom_range(0, 199) < 1);
      s[0] = ($urandom_range(0, 199) < 1);
      if (!m_run && $urandom_range(0, 99) < 5)
        TRG_RATE = {2'($urandom), 16'($urandom_range(0, 60))};
      SRC_SEL = 2'($urandom);
      if ($urandom_range(0, 99) < 5) begin
        INJ_DLY = 5'($urandom); PLS_DLY = 5'($urandom);
        L1A_DLY = 5'($urandom); LCT_DLY = 4'($urandom);
      end
      if (s != 6'd0)
        $display("txn: random cycle %0d ctl=%b rate=%0d sel=%0d", i, s, TRG_RATE[15:0], SRC_SEL);
      cyc(s);
    end
    if (m_run) cyc(P_TGL);
    wait_cyc(1700);

    @(negedge CLKCMS); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
